jump_seq_ctrl: RTL and testbench
================================

Name: jump_seq_ctrl

Overview:
- Sequencing controller for the PC jump path; sits between decode, EX-stage ALU zero flag and the PC/pipeline registers.
- Captures a jump request at decode, resolves the jump condition in the following cycle from the ALU zero flag, then drives the PC load and pipeline flush.
- Replaces the bare combinational jump enable with a registered, stall-aware, single-outstanding-jump sequence.

Parameters:
- ADDR_W, 16, PC/target address width.
- FLUSH_CYCLES, 2, cycles flush is held after a taken jump (1..15).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- stall  in  1  pipeline stall from hazard unit; freezes the sequencer.
- id_valid  in  1  decode slot holds a valid instruction.
- jump_en_op  in  2  jump op from decode: NOP=00, EN=01, ZEROJ=10, NZEROJ=11 (define.v JUMP_EN_OP_* encodings).
- jump_target  in  ADDR_W  target address from decode.
- zero  in  1  ALU zero flag (alu_A == 0), valid in the cycle after capture.
- busy  out  1  sequencer not IDLE; decode must not issue a new jump.
- pc_jump  out  1  one-cycle PC load strobe.
- pc_target  out  ADDR_W  address loaded on pc_jump.
- flush  out  1  squash IF/ID contents.

Behaviour:
- Reset (rst=1 at clk edge): state=IDLE, busy=0, pc_jump=0, pc_target=0, flush=0, flush counter=0, latched op=NOP. Overrides every other input, including mid-sequence.
- All outputs are registered; no combinational path from input to output.
- IDLE:
  - Capture when id_valid=1, stall=0 and jump_en_op != NOP: latch op and target, go to EVAL, busy=1 next cycle.
  - jump_en_op=NOP or id_valid=0: stay in IDLE, all outputs 0.
- EVAL:
  - stall=1: hold state and latches; outputs unchanged (pc_jump=0).
  - stall=0: taken = 1 for EN, zero for ZEROJ, ~zero for NZEROJ.
  - Taken: next cycle pc_jump=1, pc_target=latched target, flush=1, counter=FLUSH_CYCLES-1; go to FLUSH, or to IDLE directly if FLUSH_CYCLES=1.
  - Not taken: go to IDLE; pc_jump=0, flush=0.
- FLUSH:
  - flush=1, busy=1, pc_jump=0 (pc_jump is exactly one cycle wide).
  - Counter decrements every cycle regardless of stall; flush is not suspended by stall.
  - At counter=0 the next state is IDLE, and flush and busy drop in that same cycle.
  - Total flush high time = FLUSH_CYCLES cycles, beginning with the pc_jump cycle.
- Requests arriving while busy=1 are ignored; decode is responsible for holding them.
- pc_target holds its last value when pc_jump=0.
- Counter width is 4 bits; no wrap is possible because the counter only decrements to 0.
- Simultaneous rst and any request: reset wins.

Optional Feature:
- Macro JUMP_SEQ_STATS_EN.
- Defined:
  - Adds outputs taken_cnt and not_taken_cnt, 16 bits each.
  - Each increments on EVAL resolution with stall=0; reset to 0 by rst; saturates at 0xFFFF.
- Undefined: neither the counters nor the ports exist; behaviour is otherwise identical.

Test Plan:
- Unconditional: rst, then id_valid=1, op=01, target=0x0040 -> busy=1 next cycle; pc_jump=1 with pc_target=0x0040 one cycle later; flush high 2 cycles; busy=0 after.
- ZEROJ both ways: op=10, target=0x0100, zero=1 in EVAL -> pc_jump=1, pc_target=0x0100. Repeat with zero=0 -> pc_jump stays 0, flush stays 0, IDLE in 2 cycles.
- NZEROJ with stall: op=11, zero=0, stall=1 for 3 cycles in EVAL -> no pc_jump during stall; pc_jump=1 exactly one cycle after stall falls.
- Busy rejection: second request op=01, target=0x0200 during FLUSH -> ignored; pc_target remains the first target; only one pc_jump pulse.
- Reset mid-FLUSH: assert rst in the first FLUSH cycle -> next cycle flush=0, busy=0, pc_target=0; a new request is accepted normally afterwards.
- JUMP_SEQ_STATS_EN: 3 taken + 2 not-taken jumps -> taken_cnt=3, not_taken_cnt=2. Force taken_cnt=0xFFFF, run one more taken jump -> taken_cnt stays 0xFFFF.

Source files
------------

// File: rtl/jump_seq_ctrl.sv
// jump_seq_ctrl: registered, stall-aware sequencer for the PC jump path.
// A decoded jump is captured in IDLE, resolved one cycle later against the
// ALU zero flag (EVAL), then a one-cycle PC load strobe is issued together
// with a flush of IF/ID that lasts FLUSH_CYCLES cycles (FLUSH).
// Optional build macro: JUMP_SEQ_STATS_EN adds saturating taken/not-taken
// counters (taken_cnt_o, not_taken_cnt_o).
module jump_seq_ctrl #(
    parameter int ADDR_W       = 16,
    parameter int FLUSH_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall_i,
    input  logic              id_valid_i,
    input  logic [1:0]        jump_en_op_i,
    input  logic [ADDR_W-1:0] jump_target_i,
    input  logic              zero_i,
    output logic              busy_o,
    output logic              pc_jump_o,
    output logic [ADDR_W-1:0] pc_target_o,
    output logic              flush_o
`ifdef JUMP_SEQ_STATS_EN
    ,
    output logic [15:0]       taken_cnt_o,
    output logic [15:0]       not_taken_cnt_o
`endif
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_EVAL  = 2'd1;
    localparam logic [1:0] S_FLUSH = 2'd2;

    localparam logic [1:0] OP_NOP    = 2'b00;
    localparam logic [1:0] OP_EN     = 2'b01;
    localparam logic [1:0] OP_ZEROJ  = 2'b10;
    localparam logic [1:0] OP_NZEROJ = 2'b11;

    // Counter reload: the pc_jump cycle already counts as the first flush cycle.
    localparam logic [3:0] FLUSH_INIT = 4'(FLUSH_CYCLES - 1);

    logic [1:0]        state_q, state_d;
    logic [1:0]        op_q, op_d;
    logic [ADDR_W-1:0] tgt_q, tgt_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              busy_q, busy_d;
    logic              pc_jump_q, pc_jump_d;
    logic [ADDR_W-1:0] pc_target_q, pc_target_d;
    logic              flush_q, flush_d;
    logic              taken;
    logic              eval_fire;

    // Jump condition from the latched op and the zero flag of this cycle.
    always_comb begin
        taken = 1'b0;
        case (op_q)
            OP_EN:     taken = 1'b1;
            OP_ZEROJ:  taken = zero_i;
            OP_NZEROJ: taken = ~zero_i;
            default:   taken = 1'b0;
        endcase
    end

    // Next-state and next-output logic; outputs are registered below.
    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        tgt_d       = tgt_q;
        cnt_d       = cnt_q;
        pc_jump_d   = 1'b0;
        pc_target_d = pc_target_q;
        flush_d     = 1'b0;
        eval_fire   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (id_valid_i && !stall_i && jump_en_op_i != OP_NOP) begin
                    op_d    = jump_en_op_i;
                    tgt_d   = jump_target_i;
                    state_d = S_EVAL;
                end
            end
            S_EVAL: begin
                // A stall freezes resolution; latches and outputs hold.
                if (!stall_i) begin
                    eval_fire = 1'b1;
                    if (taken) begin
                        pc_jump_d   = 1'b1;
                        pc_target_d = tgt_q;
                        flush_d     = 1'b1;
                        cnt_d       = FLUSH_INIT;
                        state_d     = (FLUSH_CYCLES == 1) ? S_IDLE : S_FLUSH;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            S_FLUSH: begin
                // Flush is never suspended by a stall.
                if (cnt_q == 4'd0) begin
                    state_d = S_IDLE;
                end else begin
                    cnt_d   = cnt_q - 4'd1;
                    flush_d = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
        busy_d = (state_d != S_IDLE);
    end

    // State, latches and registered outputs; reset overrides any request.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            op_q        <= OP_NOP;
            tgt_q       <= '0;
            cnt_q       <= 4'd0;
            busy_q      <= 1'b0;
            pc_jump_q   <= 1'b0;
            pc_target_q <= '0;
            flush_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            tgt_q       <= tgt_d;
            cnt_q       <= cnt_d;
            busy_q      <= busy_d;
            pc_jump_q   <= pc_jump_d;
            pc_target_q <= pc_target_d;
            flush_q     <= flush_d;
        end
    end

    assign busy_o      = busy_q;
    assign pc_jump_o   = pc_jump_q;
    assign pc_target_o = pc_target_q;
    assign flush_o     = flush_q;

`ifdef JUMP_SEQ_STATS_EN
    logic [15:0] taken_cnt_q;
    logic [15:0] not_taken_cnt_q;

    // Saturating resolution statistics, counted when EVAL resolves.
    always_ff @(posedge clk) begin
        if (rst) begin
            taken_cnt_q     <= 16'd0;
            not_taken_cnt_q <= 16'd0;
        end else if (eval_fire) begin
            if (taken && taken_cnt_q != 16'hFFFF)
                taken_cnt_q <= taken_cnt_q + 16'd1;
            if (!taken && not_taken_cnt_q != 16'hFFFF)
                not_taken_cnt_q <= not_taken_cnt_q + 16'd1;
        end
    end

    assign taken_cnt_o     = taken_cnt_q;
    assign not_taken_cnt_o = not_taken_cnt_q;
`endif

endmodule

// File: tb/tb_jump_seq_ctrl.sv
// tb_jump_seq_ctrl: directed stimulus for jump_seq_ctrl, checked every cycle
// against a transaction-level model, plus literal expectations per scenario.
module tb_jump_seq_ctrl;
    localparam int AW = 16;
    localparam int FC = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          stall = 1'b0;
    logic          id_valid = 1'b0;
    logic [1:0]    op = 2'b00;
    logic [AW-1:0] tgt = '0;
    logic          zero = 1'b0;
    logic          busy, pc_jump, flush;
    logic [AW-1:0] pc_target;
`ifdef JUMP_SEQ_STATS_EN
    logic [15:0]   taken_cnt, not_taken_cnt;
`endif

    int checks = 0;
    int errors = 0;

    jump_seq_ctrl #(.ADDR_W(AW), .FLUSH_CYCLES(FC)) dut (
        .clk(clk), .rst(rst), .stall_i(stall), .id_valid_i(id_valid),
        .jump_en_op_i(op), .jump_target_i(tgt), .zero_i(zero),
        .busy_o(busy), .pc_jump_o(pc_jump), .pc_target_o(pc_target),
        .flush_o(flush)
`ifdef JUMP_SEQ_STATS_EN
        , .taken_cnt_o(taken_cnt), .not_taken_cnt_o(not_taken_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- transaction-level model ----------------
    // A captured jump is pending until one unstalled cycle resolves it; a taken
    // jump opens a flush window of FC cycles, the first carrying the PC strobe.
    bit            m_live = 0;
    bit            m_pend = 0;
    logic [1:0]    m_op = '0;
    logic [AW-1:0] m_tgt = '0;
    int            m_left = 0;
    logic          e_busy = 0, e_pcj = 0, e_flush = 0;
    logic [AW-1:0] e_tgt = '0;
    logic [15:0]   m_tk = 0, m_nt = 0;

    always @(posedge clk) begin
        bit tk;
        bit pj;
        if (rst) begin
            m_live = 1; m_pend = 0; m_left = 0;
            e_busy = 0; e_pcj = 0; e_flush = 0; e_tgt = '0;
            m_tk = 0; m_nt = 0;
        end else begin
            pj = 0;
            if (m_left > 0) m_left--;
            if (m_pend) begin
                if (!stall) begin
                    m_pend = 0;
                    tk = (m_op == 2'b01) || (m_op == 2'b10 && zero) || (m_op == 2'b11 && !zero);
                    if (tk) begin
                        pj = 1; e_tgt = m_tgt; m_left = FC;
                        if (m_tk != 16'hFFFF) m_tk++;
                    end else if (m_nt != 16'hFFFF) begin
                        m_nt++;
                    end
                end
            end else if (!e_busy && id_valid && !stall && op != 2'b00) begin
                m_pend = 1; m_op = op; m_tgt = tgt;
            end
            e_pcj   = pj;
            e_flush = (m_left > 0);
            e_busy  = m_pend || (m_left > 0 && FC > 1);
        end
        #1;
        if (m_live) begin
            chk("model_busy", 32'(busy), 32'(e_busy));
            chk("model_pc_jump", 32'(pc_jump), 32'(e_pcj));
            chk("model_pc_target", 32'(pc_target), 32'(e_tgt));
            chk("model_flush", 32'(flush), 32'(e_flush));
`ifdef JUMP_SEQ_STATS_EN
            chk("model_taken_cnt", 32'(taken_cnt), 32'(m_tk));
            chk("model_not_taken_cnt", 32'(not_taken_cnt), 32'(m_nt));
`endif
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic nedge(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic req(input logic v, input logic [1:0] o, input logic [AW-1:0] t);
        id_valid = v; op = o; tgt = t;
    endtask

    task automatic run_jump(input logic [1:0] o, input logic z);
        req(1, o, 16'h0A00); zero = z;
        nedge(1); req(0, 2'b00, '0);
        nedge(4);
    endtask

    initial begin
        int pulses;
        // Reset held while a request is presented: reset wins.
        req(1, 2'b01, 16'h1234);
        nedge(2);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_pc_jump", 32'(pc_jump), 32'd0);
        chk("rst_pc_target", 32'(pc_target), 32'd0);
        chk("rst_flush", 32'(flush), 32'd0);
        req(0, 2'b00, '0); rst = 0;
        nedge(1);

        // Stall in IDLE blocks capture.
        stall = 1; req(1, 2'b01, 16'h0077);
        nedge(1);
        chk("idle_stall_busy", 32'(busy), 32'd0);
        stall = 0; req(0, 2'b00, '0);
        nedge(1);

        // Unconditional jump.
        req(1, 2'b01, 16'h0040);
        nedge(1); req(0, 2'b00, '0);
        chk("en_busy", 32'(busy), 32'd1);
        chk("en_pc_jump_early", 32'(pc_jump), 32'd0);
        nedge(1);
        chk("en_pc_jump", 32'(pc_jump), 32'd1);
        chk("en_pc_target", 32'(pc_target), 32'h0040);
        chk("en_flush1", 32'(flush), 32'd1);
        nedge(1);
        chk("en_pc_jump_off", 32'(pc_jump), 32'd0);
        chk("en_flush2", 32'(flush), 32'd1);
        chk("en_busy2", 32'(busy), 32'd1);
        nedge(1);
        chk("en_flush_done", 32'(flush), 32'd0);
        chk("en_busy_done", 32'(busy), 32'd0);
        chk("en_target_hold", 32'(pc_target), 32'h0040);

        // ZEROJ taken.
        req(1, 2'b10, 16'h0100); zero = 1;
        nedge(1); req(0, 2'b00, '0);
        nedge(1);
        chk("zj_t_pc_jump", 32'(pc_jump), 32'd1);
        chk("zj_t_pc_target", 32'(pc_target), 32'h0100);
        nedge(3);

        // ZEROJ not taken.
        req(1, 2'b10, 16'h0180); zero = 0;
        nedge(1); req(0, 2'b00, '0);
        chk("zj_n_busy", 32'(busy), 32'd1);
        nedge(1);
        chk("zj_n_pc_jump", 32'(pc_jump), 32'd0);
        chk("zj_n_flush", 32'(flush), 32'd0);
        chk("zj_n_busy_idle", 32'(busy), 32'd0);
        chk("zj_n_target_hold", 32'(pc_target), 32'h0100);
        nedge(1);

        // NZEROJ with a 3-cycle stall in EVAL.
        req(1, 2'b11, 16'h0ABC); zero = 0;
        nedge(1); req(0, 2'b00, '0); stall = 1;
        for (int i = 0; i < 3; i++) begin
            nedge(1);
            chk("nz_stall_pc_jump", 32'(pc_jump), 32'd0);
            chk("nz_stall_busy", 32'(busy), 32'd1);
        end
        stall = 0;
        nedge(1);
        chk("nz_pc_jump", 32'(pc_jump), 32'd1);
        chk("nz_pc_target", 32'(pc_target), 32'h0ABC);
        // Stall during FLUSH does not extend it.
        stall = 1;
        nedge(2);
        chk("nz_flush_stall_done", 32'(flush), 32'd0);
        stall = 0;
        nedge(1);

        // Busy rejection: second request during the flush window.
        pulses = 0;
        req(1, 2'b01, 16'h0300);
        nedge(1); req(0, 2'b00, '0);
        nedge(1);
        req(1, 2'b01, 16'h0200);
        for (int i = 0; i < 6; i++) begin
            if (pc_jump) pulses++;
            if (i == 1) req(0, 2'b00, '0);
            nedge(1);
        end
        chk("busy_rej_pulses", 32'(pulses), 32'd1);
        chk("busy_rej_target", 32'(pc_target), 32'h0300);

        // Reset in the first flush cycle, then a fresh request.
        req(1, 2'b01, 16'h0444);
        nedge(1); req(0, 2'b00, '0);
        nedge(1);
        chk("rmf_pc_jump", 32'(pc_jump), 32'd1);
        rst = 1;
        nedge(1);
        chk("rmf_flush", 32'(flush), 32'd0);
        chk("rmf_busy", 32'(busy), 32'd0);
        chk("rmf_pc_target", 32'(pc_target), 32'd0);
        rst = 0;
        req(1, 2'b01, 16'h0500);
        nedge(1); req(0, 2'b00, '0);
        chk("rmf_new_busy", 32'(busy), 32'd1);
        nedge(1);
        chk("rmf_new_pc_jump", 32'(pc_jump), 32'd1);
        chk("rmf_new_target", 32'(pc_target), 32'h0500);
        nedge(3);

`ifdef JUMP_SEQ_STATS_EN
        rst = 1; nedge(1); rst = 0; nedge(1);
        run_jump(2'b01, 0);
        run_jump(2'b10, 0);
        run_jump(2'b10, 1);
        run_jump(2'b11, 1);
        run_jump(2'b11, 0);
        chk("stats_taken", 32'(taken_cnt), 32'd3);
        chk("stats_not_taken", 32'(not_taken_cnt), 32'd2);
        force dut.taken_cnt_q = 16'hFFFF;
        m_tk = 16'hFFFF;
        nedge(1);
        release dut.taken_cnt_q;
        run_jump(2'b01, 0);
        chk("stats_saturate", 32'(taken_cnt), 32'hFFFF);
`endif

        nedge(2);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
